// File: rtl/adder.sv
// Registered WIDTH-bit adder with carry, signed-overflow and zero flags; one-cycle latency.
// Define ADDER_CARRY_IN_EN to add a carry-in port (cin) sampled alongside a/b.
module adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ADDER_CARRY_IN_EN
  input  logic             cin,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             carry,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             overflow,
  output logic             zero
);

  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic             w_overflow;
  logic             w_zero;

  logic [WIDTH-1:0] r_out;
  logic             r_carry;
  logic             r_overflow;
  logic             r_zero;
  logic             r_valid;

`ifdef ADDER_CARRY_IN_EN
  assign w_cin = cin;
`else
  assign w_cin = 1'b0;
`endif

  always_comb begin
    w_sum      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, w_cin};
    // Signed overflow: like-signed operands producing a result of the other sign.
    w_overflow = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    w_zero     = (w_sum[WIDTH-1:0] == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out      <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_out      <= w_sum[WIDTH-1:0];
        r_carry    <= w_sum[WIDTH];
        r_overflow <= w_overflow;
        r_zero     <= w_zero;
      end
    end
  end

  assign out       = r_out;
  assign carry     = r_carry;
  assign overflow  = r_overflow;
  assign zero      = r_zero;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_adder.sv
// Scoreboard bench for adder: stimulus pushes hand-computed results, a negedge monitor pops them.
module tb_adder;

  localparam int unsigned W = 4;

  typedef struct {
    logic [W-1:0] o;
    logic         c;
    logic         ov;
    logic         z;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         in_valid;
  logic         carry;
  logic [W-1:0] out;
  logic         out_valid;
  logic         overflow;
  logic         zero;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef ADDER_CARRY_IN_EN
    .cin       (cin),
`endif
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .carry     (carry),
    .out       (out),
    .out_valid (out_valid),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Present one operand pair for one edge and record its expected result.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                       input logic [W-1:0] eo, input logic ec, input logic eov,
                       input logic ez);
    exp_t e;
    a = ia; b = ib; cin = ic; in_valid = 1'b1; rst = 1'b0;
    e.o = eo; e.c = ec; e.ov = eov; e.z = ez;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic chk_zero_state(input string tag);
    chk({tag, "_out"}, 32'(out), 0);
    chk({tag, "_carry"}, 32'(carry), 0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
    chk({tag, "_zero"}, 32'(zero), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 32'(out_valid), 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out", 32'(out), 32'(e.o));
        chk("carry", 32'(carry), 32'(e.c));
        chk("overflow", 32'(overflow), 32'(e.ov));
        chk("zero", 32'(zero), 32'(e.z));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset for two edges with operands offered; they must be dropped.
    rst = 1'b1; a = 4'd9; b = 4'd9; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    chk_zero_state("reset1");
    @(posedge clk); #1;
    chk_zero_state("reset2");

    //    a      b      cin   out    c     ov    z
    issue(4'd0,  4'd0,  1'b0, 4'd0,  1'b0, 1'b0, 1'b1);
    issue(4'd5,  4'd5,  1'b0, 4'd10, 1'b0, 1'b1, 1'b0);
    issue(4'd15, 4'd15, 1'b0, 4'd14, 1'b1, 1'b0, 1'b0);
    issue(4'd7,  4'd1,  1'b0, 4'd8,  1'b0, 1'b1, 1'b0);
    issue(4'd9,  4'd7,  1'b0, 4'd0,  1'b1, 1'b0, 1'b1);
`ifdef ADDER_CARRY_IN_EN
    issue(4'd15, 4'd0,  1'b1, 4'd0,  1'b1, 1'b0, 1'b1);
`endif
    // Back-to-back stream, then an idle edge: results must hold.
    issue(4'd3,  4'd4,  1'b0, 4'd7,  1'b0, 1'b0, 1'b0);
    issue(4'd8,  4'd8,  1'b0, 4'd0,  1'b1, 1'b1, 1'b1);
    issue(4'd1,  4'd14, 1'b0, 4'd15, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("hold_out_valid", 32'(out_valid), 0);
    chk("hold_out", 32'(out), 15);
    chk("hold_carry", 32'(carry), 0);
    chk("hold_zero", 32'(zero), 0);
    @(posedge clk); #1;
    chk("hold_out_2", 32'(out), 15);

    // (7,7) presented while reset is asserted: it must never surface as 14.
    a = 4'd7; b = 4'd7; in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    chk_zero_state("midreset");
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_idle", 32'(out_valid), 0);

    issue(4'd2,  4'd3,  1'b0, 4'd5,  1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
